// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU issued from EX.
// Yields {remainder, quotient} and stalls the pipe while busy.
module div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_div,
   input  logic [WIDTH-1:0]     opdata1,
   input  logic [WIDTH-1:0]     opdata2,
   input  logic                 annul,
   output logic [2*WIDTH-1:0]   result,
   output logic                 ready,
   output logic                 stallreq_for_ex
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      BYZERO,
      RUN,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 negq_q, negq_d;
   logic                 negr_q, negr_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 ready_q, ready_d;

   logic [WIDTH:0]       rem_sh;
   logic [WIDTH-1:0]     rem_sub;
   logic                 ge;
   logic [WIDTH-1:0]     rem_nx;
   logic [WIDTH-1:0]     quo_nx;
   logic [WIDTH-1:0]     q_fix;
   logic [WIDTH-1:0]     r_fix;
   logic [WIDTH-1:0]     abs1;
   logic [WIDTH-1:0]     abs2;

   // One restoring step plus the final sign fix-up of its outcome.
   always_comb begin
      rem_sh  = {rem_q, quo_q[WIDTH-1]};
      ge      = rem_sh >= {1'b0, dvs_q};
      rem_sub = rem_sh[WIDTH-1:0] - dvs_q;
      rem_nx  = ge ? rem_sub : rem_sh[WIDTH-1:0];
      quo_nx  = {quo_q[WIDTH-2:0], ge};
      q_fix   = negq_q ? -quo_nx : quo_nx;
      r_fix   = negr_q ? -rem_nx : rem_nx;
      abs1    = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
      abs2    = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
   end

   // Next-state and datapath control; annul overrides every transition.
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      cnt_d    = cnt_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      result_d = result_q;
      ready_d  = ready_q;
      unique case (state_q)
         IDLE: begin
            ready_d = 1'b0;
            if (start && !annul) begin
               if (opdata2 == '0) begin
                  state_d = BYZERO;
               end else begin
                  state_d = RUN;
                  rem_d   = '0;
                  quo_d   = abs1;
                  dvs_d   = abs2;
                  cnt_d   = '0;
                  negq_d  = signed_div
                          & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                  negr_d  = signed_div & opdata1[WIDTH-1];
               end
            end
         end
         BYZERO: begin
            if (annul) begin
               state_d = IDLE;
               ready_d = 1'b0;
            end else begin
               state_d  = DONE;
               result_d = '0;
               ready_d  = 1'b1;
            end
         end
         RUN: begin
            if (annul) begin
               state_d = IDLE;
               ready_d = 1'b0;
            end else begin
               rem_d = rem_nx;
               quo_d = quo_nx;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_d  = DONE;
                  result_d = {r_fix, q_fix};
                  ready_d  = 1'b1;
               end
            end
         end
         DONE: begin
            if (annul || !start) begin
               state_d = IDLE;
               ready_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         cnt_q    <= cnt_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result          = result_q;
   assign ready           = ready_q;
   assign stallreq_for_ex = start & ~ready_q & ~annul;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit.
// Cycle-level reference model plus directed literal checks.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        signed_div = 1'b0;
   logic [31:0] opdata1 = '0;
   logic [31:0] opdata2 = '0;
   logic        annul = 1'b0;
   logic [63:0] result;
   logic        ready;
   logic        stallreq_for_ex;

   int n_vec = 0;
   int n_err = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .signed_div      (signed_div),
      .opdata1         (opdata1),
      .opdata2         (opdata2),
      .annul           (annul),
      .result          (result),
      .ready           (ready),
      .stallreq_for_ex (stallreq_for_ex)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h @%0t",
                  name, act, exp, $time);
      end
   endtask

   // Plain-arithmetic reference: truncating division, 64-bit headroom.
   function automatic logic [63:0] ref_div(input logic sd,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 0) return 64'd0;
      if (sd) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Timing model: ready after a fixed number of edges from acceptance.
   logic        m_ready = 1'b0;
   logic [63:0] m_result = '0;
   logic [63:0] m_val = '0;
   logic        m_pend = 1'b0;
   int          m_left = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ready  = 1'b0;
         m_result = '0;
         m_pend   = 1'b0;
         m_left   = 0;
      end else if ((m_pend || m_ready) && annul) begin
         m_pend  = 1'b0;
         m_ready = 1'b0;
      end else if (m_pend) begin
         m_left--;
         if (m_left == 0) begin
            m_pend   = 1'b0;
            m_ready  = 1'b1;
            m_result = m_val;
         end
      end else if (m_ready) begin
         if (!start) m_ready = 1'b0;
      end else if (start && !annul) begin
         m_pend = 1'b1;
         m_val  = ref_div(signed_div, opdata1, opdata2);
         m_left = (opdata2 == 0) ? 1 : 32;
      end
   end

   // Mid-cycle comparison of every output against the model.
   always @(negedge clk) begin
      chk("ready", {63'd0, ready}, {63'd0, m_ready});
      chk("result", result, m_result);
      chk("stallreq", {63'd0, stallreq_for_ex},
          {63'd0, start && !m_ready && !annul});
   end

   // Issue one division at posedge+1; returns at posedge+1 back in IDLE.
   task automatic run_div(input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input bit lit,
                          input logic [63:0] exp, input int hold);
      int n;
      int lat;
      lat = (b == 0) ? 2 : 33;
      signed_div = sd;
      opdata1    = a;
      opdata2    = b;
      start      = 1'b1;
      @(posedge clk); #1;
      signed_div = ~sd;
      opdata1    = $urandom;
      opdata2    = $urandom;
      n = 1;
      while (!ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", 64'(n), 64'(lat));
      chk("stall_at_ready", {63'd0, stallreq_for_ex}, 64'd0);
      if (lit) chk("result_lit", result, exp);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      if (lit) chk("result_held", result, exp);
      start = 1'b0;
      @(posedge clk); #1;
      chk("ready_drop", {63'd0, ready}, 64'd0);
   endtask

   initial begin
      #1 rst = 1'b0;
      #1;
      chk("rst_result", result, 64'd0);
      chk("rst_ready", {63'd0, ready}, 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      run_div(1'b0, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14}, 3);
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1,
              {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
      run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1,
              {32'h0000_0001, 32'hFFFF_FFFD}, 1);
      run_div(1'b1, 32'd5, 32'd0, 1'b1, 64'd0, 2);
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
              {32'd0, 32'h8000_0000}, 0);
      run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
              {32'h8000_0000, 32'd0}, 0);

      // annul in the middle of RUN
      signed_div = 1'b0;
      opdata1    = 32'd1000;
      opdata2    = 32'd3;
      start      = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
      end
      annul = 1'b1;
      start = 1'b0;
      @(posedge clk); #1;
      annul = 1'b0;
      chk("annul_ready", {63'd0, ready}, 64'd0);
      repeat (40) begin
         @(posedge clk); #1;
      end
      chk("annul_never", {63'd0, ready}, 64'd0);
      run_div(1'b0, 32'd9, 32'd3, 1'b1, {32'd0, 32'd3}, 0);

      // asynchronous reset in the middle of RUN
      signed_div = 1'b0;
      opdata1    = 32'd12345;
      opdata2    = 32'd10;
      start      = 1'b1;
      repeat (15) begin
         @(posedge clk); #1;
      end
      #2;
      rst   = 1'b0;
      start = 1'b0;
      #1;
      chk("arst_result", result, 64'd0);
      chk("arst_ready", {63'd0, ready}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1,
              {32'd0, 32'hFFFF_FFFF}, 0);

      // model-only checks on a few scattered operands
      for (int i = 0; i < 6; i++) begin
         run_div(1'(i % 2), $urandom, $urandom_range(1, 1000), 1'b0,
                 64'd0, i % 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
